// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with arbitrary depth, programmable threshold flags and flush.
// Define FIFO_FWFT_EN for a first-word-fall-through read port.
module sync_fifo_prog #(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  rd_en,
   input  logic [CNT_W-1:0]      prog_full_thresh,
   input  logic [CNT_W-1:0]      prog_empty_thresh,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  rd_valid,
   output logic                  wr_ack,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  full,
   output logic                  empty,
   output logic                  almostfull,
   output logic                  almostempty,
   output logic                  prog_full,
   output logic                  prog_empty,
   output logic [CNT_W-1:0]      count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(FIFO_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic                  wr_acc;
   logic                  rd_acc;

   assign full        = (count == CNT_FULL);
   assign empty       = (count == '0);
   assign almostfull  = (count == CNT_AF);
   assign almostempty = (count == CNT_ONE);
   assign prog_full   = (count >= prog_full_thresh);
   assign prog_empty  = (count <= prog_empty_thresh);

   assign wr_acc = wr_en & ~full;
   assign rd_acc = rd_en & ~empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         wr_ack    <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         wr_ack    <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         // Depth need not be a power of two, so wrap explicitly.
         if (wr_acc)
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
         if (rd_acc)
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         wr_ack    <= wr_acc;
         overflow  <= wr_en & full;
         underflow <= rd_en & empty;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !flush && wr_acc)
         mem[wr_ptr] <= data_in;
   end

`ifdef FIFO_FWFT_EN
   assign data_out = mem[rd_ptr];
   assign rd_valid = ~empty;
`else
   always_ff @(posedge clk) begin
      if (rst) begin
         data_out <= '0;
         rd_valid <= 1'b0;
      end else if (flush) begin
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_acc;
         if (rd_acc)
            data_out <= mem[rd_ptr];
      end
   end
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog, depth 5, registered read path.
module tb_sync_fifo_prog;

   localparam int DW = 16;
   localparam int DEPTH = 5;
   localparam int CW = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          flush = 1'b0;
   logic          wr_en = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic          rd_en = 1'b0;
   logic [CW-1:0] prog_full_thresh = CW'(5);
   logic [CW-1:0] prog_empty_thresh = '0;
   logic [DW-1:0] data_out;
   logic          rd_valid, wr_ack, overflow, underflow;
   logic          full, empty, almostfull, almostempty;
   logic          prog_full, prog_empty;
   logic [CW-1:0] count;

   int n_checks = 0;
   int n_fails = 0;

   sync_fifo_prog #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
      .prog_full_thresh(prog_full_thresh),
      .prog_empty_thresh(prog_empty_thresh),
      .data_out(data_out), .rd_valid(rd_valid),
      .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
      .full(full), .empty(empty),
      .almostfull(almostfull), .almostempty(almostempty),
      .prog_full(prog_full), .prog_empty(prog_empty),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         rst = 1'b1;
         wr_en = 1'($urandom_range(0, 1));
         rd_en = 1'($urandom_range(0, 1));
         data_in = DW'($urandom);
         step();
      end
      rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      n_checks++;
      if (count !== '0) begin
         n_fails++; $display("FAIL reset_count got %0d exp 0", count);
      end
      n_checks++;
      if (empty !== 1'b1 || full !== 1'b0 || almostempty !== 1'b0 || almostfull !== 1'b0) begin
         n_fails++;
         $display("FAIL reset_flags got e%b f%b ae%b af%b exp e1 f0 ae0 af0",
                  empty, full, almostempty, almostfull);
      end
      n_checks++;
      if ({wr_ack, overflow, underflow, rd_valid} !== 4'b0000) begin
         n_fails++;
         $display("FAIL reset_pulses got %b exp 0000", {wr_ack, overflow, underflow, rd_valid});
      end
      n_checks++;
      if (data_out !== '0) begin
         n_fails++; $display("FAIL reset_data_out got %h exp 0", data_out);
      end
   endtask

   task automatic test_fill_overflow();
      do_reset();
      for (int i = 1; i <= DEPTH; i++) begin
         wr_en = 1'b1; data_in = DW'(i);
         step();
         n_checks++;
         if (wr_ack !== 1'b1 || count !== CW'(i)) begin
            n_fails++;
            $display("FAIL fill_%0d got ack %b cnt %0d exp ack 1 cnt %0d", i, wr_ack, count, i);
         end
         n_checks++;
         if (almostfull !== (i == DEPTH - 1) || full !== (i == DEPTH)) begin
            n_fails++;
            $display("FAIL fill_flags_%0d got af%b f%b exp af%b f%b",
                     i, almostfull, full, i == DEPTH - 1, i == DEPTH);
         end
      end
      data_in = 16'h0006;
      step();
      wr_en = 1'b0;
      n_checks++;
      if (overflow !== 1'b1 || wr_ack !== 1'b0 || count !== CW'(5)) begin
         n_fails++;
         $display("FAIL overflow got ov%b ack%b cnt %0d exp ov1 ack0 cnt 5",
                  overflow, wr_ack, count);
      end
   endtask

   task automatic test_wrap_order();
      logic [DW-1:0] exp_d;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         wr_en = 1'b1; data_in = DW'(i + 1);
         step();
      end
      wr_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rd_en = 1'b1;
         step();
         n_checks++;
         if (rd_valid !== 1'b1 || data_out !== DW'(i + 1)) begin
            n_fails++;
            $display("FAIL pre_read_%0d got v%b %h exp v1 %h", i, rd_valid, data_out, i + 1);
         end
      end
      rd_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; data_in = DW'(16'h000A + i);
         step();
      end
      wr_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rd_en = 1'b1;
         step();
         exp_d = DW'(16'h000A + i);
         n_checks++;
         if (rd_valid !== 1'b1 || data_out !== exp_d) begin
            n_fails++;
            $display("FAIL wrap_read_%0d got v%b %h exp v1 %h", i, rd_valid, data_out, exp_d);
         end
      end
      rd_en = 1'b0;
      step();
      n_checks++;
      if (empty !== 1'b1 || rd_valid !== 1'b0 || count !== '0) begin
         n_fails++;
         $display("FAIL wrap_drained got e%b v%b cnt %0d exp e1 v0 cnt 0", empty, rd_valid, count);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      wr_en = 1'b1; rd_en = 1'b1; data_in = 16'h0055;
      step();
      n_checks++;
      if (count !== CW'(1) || underflow !== 1'b1 || wr_ack !== 1'b1 || rd_valid !== 1'b0) begin
         n_fails++;
         $display("FAIL simul_empty got cnt %0d uf%b ack%b v%b exp cnt 1 uf1 ack1 v0",
                  count, underflow, wr_ack, rd_valid);
      end
      rd_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         data_in = DW'(16'h0056 + i);
         step();
      end
      rd_en = 1'b1; data_in = 16'h0099;
      step();
      n_checks++;
      if (count !== CW'(4) || overflow !== 1'b1 || wr_ack !== 1'b0 ||
          rd_valid !== 1'b1 || data_out !== 16'h0055) begin
         n_fails++;
         $display("FAIL simul_full got cnt %0d ov%b ack%b v%b %h exp cnt 4 ov1 ack0 v1 0055",
                  count, overflow, wr_ack, rd_valid, data_out);
      end
      wr_en = 1'b0;
      step();
      step();
      n_checks++;
      if (count !== CW'(2) || data_out !== 16'h0057) begin
         n_fails++;
         $display("FAIL simul_drain got cnt %0d %h exp cnt 2 0057", count, data_out);
      end
      wr_en = 1'b1; data_in = 16'h0077;
      step();
      wr_en = 1'b0; rd_en = 1'b0;
      n_checks++;
      if (count !== CW'(2) || wr_ack !== 1'b1 || rd_valid !== 1'b1 || data_out !== 16'h0058) begin
         n_fails++;
         $display("FAIL simul_mid got cnt %0d ack%b v%b %h exp cnt 2 ack1 v1 0058",
                  count, wr_ack, rd_valid, data_out);
      end
   endtask

   task automatic test_thresholds();
      logic [CW-1:0] exp_c;
      do_reset();
      prog_full_thresh = CW'(3); prog_empty_thresh = CW'(1);
      #1;
      n_checks++;
      if (prog_full !== 1'b0 || prog_empty !== 1'b1) begin
         n_fails++; $display("FAIL thresh_0 got pf%b pe%b exp pf0 pe1", prog_full, prog_empty);
      end
      for (int i = 1; i <= 3; i++) begin
         wr_en = 1'b1; data_in = DW'(16'h0100 + i);
         step();
         exp_c = CW'(i);
         n_checks++;
         if (count !== exp_c || prog_full !== (i >= 3) || prog_empty !== (i <= 1)) begin
            n_fails++;
            $display("FAIL thresh_%0d got cnt %0d pf%b pe%b exp cnt %0d pf%b pe%b",
                     i, count, prog_full, prog_empty, i, i >= 3, i <= 1);
         end
      end
      wr_en = 1'b0;
      prog_empty_thresh = CW'(3); prog_full_thresh = CW'(4);
      #1;
      n_checks++;
      if (prog_empty !== 1'b1 || prog_full !== 1'b0) begin
         n_fails++; $display("FAIL thresh_live got pe%b pf%b exp pe1 pf0", prog_empty, prog_full);
      end
      prog_full_thresh = CW'(5); prog_empty_thresh = '0;
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; data_in = DW'(16'h0200 + i);
         step();
      end
      flush = 1'b1; data_in = 16'h00BB;
      step();
      flush = 1'b0;
      n_checks++;
      if (count !== '0 || empty !== 1'b1 || wr_ack !== 1'b0 || overflow !== 1'b0 || rd_valid !== 1'b0) begin
         n_fails++;
         $display("FAIL flush got cnt %0d e%b ack%b ov%b v%b exp cnt 0 e1 ack0 ov0 v0",
                  count, empty, wr_ack, overflow, rd_valid);
      end
      n_checks++;
      if (data_out !== 16'h0000) begin
         n_fails++; $display("FAIL flush_hold got %h exp 0000", data_out);
      end
      data_in = 16'h1234;
      step();
      wr_en = 1'b0; rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      n_checks++;
      if (rd_valid !== 1'b1 || data_out !== 16'h1234 || count !== '0) begin
         n_fails++;
         $display("FAIL flush_after got v%b %h cnt %0d exp v1 1234 cnt 0", rd_valid, data_out, count);
      end
   endtask

   initial begin
      test_reset();
      test_fill_overflow();
      test_wrap_order();
      test_simultaneous();
      test_thresholds();
      test_flush();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Parametrised synchronous FIFO, the successor to the fixed-depth FIFO_INT-based FIFO.
- Adds arbitrary (non-power-of-two) depth, runtime-programmable threshold flags, a synchronous flush and an exported occupancy count.
- Optionally provides first-word-fall-through (FWFT) read mode.
- Sits between a producer and a consumer in a single clock domain. The UVM environment and SVA bind reuse its flag semantics.

Parameters:
- DATA_WIDTH, 16, width of each stored word.
- FIFO_DEPTH, 8, number of entries; any integer >= 2, power of two not required.
- CNT_W, $clog2(FIFO_DEPTH+1), width of count and threshold ports (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of contents; no data movement this cycle.
- wr_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- rd_en  in  1  read request.
- prog_full_thresh  in  CNT_W  prog_full assertion level.
- prog_empty_thresh  in  CNT_W  prog_empty assertion level.
- data_out  out  DATA_WIDTH  read data.
- rd_valid  out  1  data_out holds a newly read word.
- wr_ack  out  1  previous-cycle write was accepted.
- overflow  out  1  previous-cycle write was rejected (FIFO full).
- underflow  out  1  previous-cycle read was rejected (FIFO empty).
- full, empty, almostfull, almostempty  out  1 each  occupancy flags.
- prog_full, prog_empty  out  1 each  programmable threshold flags.
- count  out  CNT_W  current occupancy, 0..FIFO_DEPTH.

Behaviour:
- Single clock domain: clk only; rst is synchronous and active-high. All state updates on posedge clk.
- Priority per cycle: rst > flush > normal operation.

Reset (rst=1 at edge):
- wr_ptr=0, rd_ptr=0, count=0.
- data_out=0, rd_valid=0, wr_ack=0, overflow=0, underflow=0.
- Resulting flags: empty=1, almostempty=0, full=0, almostfull=0.
- Memory contents are not cleared.

Flush (flush=1, rst=0):
- Sets wr_ptr, rd_ptr and count to 0.
- Sets wr_ack, overflow, underflow and rd_valid to 0.
- data_out holds its value.
- wr_en and rd_en are ignored that cycle; no overflow or underflow pulse is raised.

Acceptance (all based on the registered count):
- wr_acc = wr_en & !full.
- rd_acc = rd_en & !empty.
- Simultaneous wr_en & rd_en:
  - empty: write only; count +1; underflow=1.
  - full: read only; count -1; overflow=1.
  - otherwise: both accepted; count unchanged.

Pointers:
- Each pointer increments by 1 on its accept.
- Wrap rule: FIFO_DEPTH-1 -> 0 (explicit compare, not natural overflow).
- mem[wr_ptr] <= data_in on wr_acc.

Registered pulses (one cycle after the request):
- wr_ack = wr_acc.
- overflow = wr_en & full.
- underflow = rd_en & empty.

Combinational flags (from count):
- full = (count==FIFO_DEPTH).
- empty = (count==0).
- almostfull = (count==FIFO_DEPTH-1).
- almostempty = (count==1).
- prog_full = (count >= prog_full_thresh).
- prog_empty = (count <= prog_empty_thresh).
- Thresholds are sampled live; changing them takes effect on the same cycle's flags.

Read path (default, non-FWFT):
- On rd_acc: data_out <= mem[rd_ptr] and rd_valid <= 1.
- Otherwise rd_valid <= 0 and data_out holds.
- Read latency is 1 cycle.

Invariants:
- count never exceeds FIFO_DEPTH or goes below 0.
- Data order is strictly preserved across pointer wrap.

Optional Feature:
Macro: FIFO_FWFT_EN
- Defined:
  - data_out = mem[rd_ptr] combinationally.
  - rd_valid = !empty.
  - rd_en acts as a pop of the presented word.
  - A word written at edge N is visible on data_out after edge N (count updated).
  - Reset and flush force rd_valid=0 via empty.
  - data_out value while empty is don't-care.
- Undefined: registered 1-cycle read path as described in Behaviour.
- Flag, count, pointer and pulse behaviour is identical in both modes.

Test Plan:
- Reset: rst=1 for 2 cycles during random wr/rd -> count=0, empty=1, wr_ack=0, overflow=0, underflow=0, data_out=0.
- Fill/overflow (FIFO_DEPTH=5):
  - Write 1..5 -> full=1 after the 5th write; almostfull=1 at count=4.
  - A 6th write -> overflow=1 next cycle, wr_ack=0, count stays 5.
- Wrap/order (FIFO_DEPTH=5):
  - Write 3, read 3, then write 0xA..0xE.
  - Read all -> 0xA..0xE in order, rd_valid on each; pointers wrap 4 -> 0.
- Simultaneous ops:
  - wr&rd when empty -> count 0->1, underflow=1.
  - wr&rd when full -> count 5->4, overflow=1.
  - wr&rd at count=2 -> count stays 2, wr_ack=1, rd_valid=1.
- Thresholds: prog_full_thresh=3, prog_empty_thresh=1; write 3 words -> prog_full rises at count=3, prog_empty falls at count=2.
- Flush: at count=4, assert flush together with wr_en=1 -> next cycle count=0, empty=1, wr_ack=0, no overflow; a following write and read returns the new word.
